// File: rtl/tour_pkg.sv
// Purpose: shared types and constants for the knight tour move sequencer.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package tour_pkg;

    // Sequencer states: one command leg is issued, then we wait for completion.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        WAIT_V = 3'd2,
        HORZ   = 3'd3,
        WAIT_H = 3'd4
    } state_t;

    // Opcodes in cmd[15:12]
    localparam logic [3:0] MOVE         = 4'h2;
    localparam logic [3:0] MOVE_FANFARE = 4'h3;

    // Headings in cmd[11:4]
    localparam logic [7:0] NORTH = 8'h00;
    localparam logic [7:0] SOUTH = 8'h7F;
    localparam logic [7:0] WEST  = 8'h3F;
    localparam logic [7:0] EAST  = 8'hBF;

    // Response bytes back to the UART wrapper
    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_POS = 8'h5A;

    // Pack opcode, heading and square count into a 16-bit motion command.
    function automatic logic [15:0] build_cmd(input logic [3:0] op,
                                              input logic [7:0] heading,
                                              input logic [3:0] squares);
        return {op, heading, squares};
    endfunction

endpackage

// File: rtl/knight_move_decode.sv
// Purpose: turn a one-hot knight move into vertical and horizontal leg fields.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output tracks the input move every cycle.
module knight_move_decode
    import tour_pkg::*;
(
    input  logic [7:0] i_move,
    output logic [7:0] o_vert_heading,
    output logic [3:0] o_vert_sq,
    output logic [7:0] o_horz_heading,
    output logic [3:0] o_horz_sq
);

    // Lowest set bit wins; an empty move yields zero-square legs
    // (dy=0 is not positive so south, dx=0 is not positive so west).
    always_comb begin
        o_vert_heading = SOUTH;
        o_vert_sq      = 4'd0;
        o_horz_heading = WEST;
        o_horz_sq      = 4'd0;
        casez (i_move)
            8'b???????1: begin // dx +1, dy +2
                o_vert_heading = NORTH; o_vert_sq = 4'd2;
                o_horz_heading = EAST;  o_horz_sq = 4'd1;
            end
            8'b??????10: begin // dx -1, dy +2
                o_vert_heading = NORTH; o_vert_sq = 4'd2;
                o_horz_heading = WEST;  o_horz_sq = 4'd1;
            end
            8'b?????100: begin // dx -2, dy +1
                o_vert_heading = NORTH; o_vert_sq = 4'd1;
                o_horz_heading = WEST;  o_horz_sq = 4'd2;
            end
            8'b????1000: begin // dx -2, dy -1
                o_vert_heading = SOUTH; o_vert_sq = 4'd1;
                o_horz_heading = WEST;  o_horz_sq = 4'd2;
            end
            8'b???10000: begin // dx -1, dy -2
                o_vert_heading = SOUTH; o_vert_sq = 4'd2;
                o_horz_heading = WEST;  o_horz_sq = 4'd1;
            end
            8'b??100000: begin // dx +1, dy -2
                o_vert_heading = SOUTH; o_vert_sq = 4'd2;
                o_horz_heading = EAST;  o_horz_sq = 4'd1;
            end
            8'b?1000000: begin // dx +2, dy -1
                o_vert_heading = SOUTH; o_vert_sq = 4'd1;
                o_horz_heading = EAST;  o_horz_sq = 4'd2;
            end
            8'b10000000: begin // dx +2, dy +1
                o_vert_heading = NORTH; o_vert_sq = 4'd1;
                o_horz_heading = EAST;  o_horz_sq = 4'd2;
            end
            default: begin
                o_vert_heading = SOUTH; o_vert_sq = 4'd0;
                o_horz_heading = WEST;  o_horz_sq = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/tour_move_sequencer.sv
// Purpose: replay a solved knight tour as vertical + horizontal motion commands, owning the command path while active.
// Latency: first command valid one cycle after start_tour; each leg follows one cycle after the previous send_resp.
// Backpressure: a leg is held (cmd_rdy high) until clr_cmd_rdy, then the next leg waits for send_resp.
module tour_move_sequencer
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        usurp,
    output logic        mv_vert_or_horiz
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_mv_indx;

    logic [7:0]  w_vert_heading;
    logic [3:0]  w_vert_sq;
    logic [7:0]  w_horz_heading;
    logic [3:0]  w_horz_sq;
    logic [15:0] w_seq_cmd;
    logic        w_seq_rdy;
    logic        w_last_move;

    knight_move_decode u_decode (
        .i_move         (move),
        .o_vert_heading (w_vert_heading),
        .o_vert_sq      (w_vert_sq),
        .o_horz_heading (w_horz_heading),
        .o_horz_sq      (w_horz_sq)
    );

    assign w_last_move = (r_mv_indx == LAST_IDX);

    // State register; reset aborts any tour in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Move index: cleared on tour start, advanced after each completed pair,
    // never stepped past the last move so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mv_indx <= 5'd0;
        else if (r_state == IDLE && start_tour)
            r_mv_indx <= 5'd0;
        else if (r_state == WAIT_H && send_resp && !w_last_move)
            r_mv_indx <= r_mv_indx + 5'd1;
    end

    // Next state: each state only reacts to its own handshake, so stray
    // clr_cmd_rdy / send_resp / start_tour in other states are ignored.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_tour)  w_next_state = VERT;
            VERT:    if (clr_cmd_rdy) w_next_state = WAIT_V;
            WAIT_V:  if (send_resp)   w_next_state = HORZ;
            HORZ:    if (clr_cmd_rdy) w_next_state = WAIT_H;
            WAIT_H:  if (send_resp)   w_next_state = w_last_move ? IDLE : VERT;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs: sequencer command per leg, then mux against the UART path.
    always_comb begin
        usurp            = (r_state != IDLE);
        mv_vert_or_horiz = (r_state == HORZ) || (r_state == WAIT_H);
        w_seq_rdy        = (r_state == VERT) || (r_state == HORZ);
        w_seq_cmd        = mv_vert_or_horiz ?
                           build_cmd(MOVE_FANFARE, w_horz_heading, w_horz_sq) :
                           build_cmd(MOVE, w_vert_heading, w_vert_sq);
        mv_indx          = r_mv_indx;

        if (usurp) begin
            cmd              = w_seq_cmd;
            cmd_rdy          = w_seq_rdy;
            clr_cmd_rdy_UART = 1'b0;
        end else begin
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
        end

        // Positive-ack only for UART commands and the final leg of the tour.
        if (!usurp || (r_state == WAIT_H && w_last_move)) resp = RESP_ACK;
        else                                               resp = RESP_POS;
    end

endmodule

// File: tb/tb_tour_move_sequencer.sv
// Purpose: directed self-checking bench for tour_move_sequencer.
// Latency: inputs driven on the falling edge, outputs sampled 1ns later.
// Backpressure: bench plays the command processor via clr_cmd_rdy / send_resp.
module tb_tour_move_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        usurp;
    logic        mv_vert_or_horiz;

    int vecs = 0;
    int errs = 0;

    tour_move_sequencer #(.NUM_MOVES(24)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp),
        .usurp            (usurp),
        .mv_vert_or_horiz (mv_vert_or_horiz)
    );

    always #5 clk = ~clk;

    // Stimulus helpers only: advance across one rising edge and settle.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        #1;
    endtask

    task automatic pulse_send();
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        #1;
    endtask

    task automatic pulse_start();
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        vecs++; if (usurp !== 1'b0) begin errs++; $display("FAIL reset_usurp got %h want 0", usurp); end
        vecs++; if (mv_indx !== 5'd0) begin errs++; $display("FAIL reset_indx got %0d want 0", mv_indx); end
        vecs++; if (mv_vert_or_horiz !== 1'b0) begin errs++; $display("FAIL reset_vh got %h want 0", mv_vert_or_horiz); end
        vecs++; if (cmd !== 16'h1234) begin errs++; $display("FAIL reset_cmd got %h want 1234", cmd); end
        vecs++; if (cmd_rdy !== 1'b1) begin errs++; $display("FAIL reset_cmd_rdy got %h want 1", cmd_rdy); end
    endtask

    task automatic test_idle_passthrough();
        cmd_UART = 16'h0000; cmd_rdy_UART = 1'b1; #1;
        vecs++; if (cmd !== 16'h0000) begin errs++; $display("FAIL idle_cmd got %h want 0000", cmd); end
        vecs++; if (usurp !== 1'b0) begin errs++; $display("FAIL idle_usurp got %h want 0", usurp); end
        vecs++; if (resp !== 8'hA5) begin errs++; $display("FAIL idle_resp got %h want a5", resp); end
        clr_cmd_rdy = 1'b1; #1;
        vecs++; if (clr_cmd_rdy_UART !== 1'b1) begin errs++; $display("FAIL idle_clr_pass got %h want 1", clr_cmd_rdy_UART); end
        clr_cmd_rdy = 1'b0; #1;
        vecs++; if (clr_cmd_rdy_UART !== 1'b0) begin errs++; $display("FAIL idle_clr_drop got %h want 0", clr_cmd_rdy_UART); end
        cmd_UART = 16'hBEEF; cmd_rdy_UART = 1'b0; #1;
        vecs++; if (cmd !== 16'hBEEF || cmd_rdy !== 1'b0) begin errs++; $display("FAIL idle_cmd2 got %h/%h want beef/0", cmd, cmd_rdy); end
    endtask

    // Leaves the DUT in VERT at index 0 with move 8'h01.
    task automatic test_start();
        move = 8'h01;
        @(negedge clk);
        pulse_start();
        vecs++; if (usurp !== 1'b1) begin errs++; $display("FAIL start_usurp got %h want 1", usurp); end
        vecs++; if (resp !== 8'h5A) begin errs++; $display("FAIL start_resp got %h want 5a", resp); end
        vecs++; if (cmd !== 16'h2002) begin errs++; $display("FAIL start_cmd got %h want 2002", cmd); end
        vecs++; if (cmd_rdy !== 1'b1) begin errs++; $display("FAIL start_cmd_rdy got %h want 1", cmd_rdy); end
        vecs++; if (mv_indx !== 5'd0 || mv_vert_or_horiz !== 1'b0) begin errs++; $display("FAIL start_idx got %0d/%h want 0/0", mv_indx, mv_vert_or_horiz); end
        // UART handshake is cut off while sequencing
        cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1; #1;
        vecs++; if (clr_cmd_rdy_UART !== 1'b0) begin errs++; $display("FAIL usurp_clr_block got %h want 0", clr_cmd_rdy_UART); end
        clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0; #1;
    endtask

    // From VERT@0 with move 01: full pair, ends in VERT@1.
    task automatic test_handoff();
        pulse_clr();
        vecs++; if (cmd_rdy !== 1'b0 || mv_vert_or_horiz !== 1'b0) begin errs++; $display("FAIL waitv_state got rdy %h vh %h want 0/0", cmd_rdy, mv_vert_or_horiz); end
        // Robustness in WAIT_V: start_tour, UART valid and clr_cmd_rdy all ignored
        start_tour = 1'b1; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
        next_cycle();
        start_tour = 1'b0; cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0; #1;
        vecs++; if (cmd_rdy !== 1'b0 || mv_vert_or_horiz !== 1'b0 || mv_indx !== 5'd0 || usurp !== 1'b1)
            begin errs++; $display("FAIL waitv_robust got rdy %h vh %h idx %0d us %h want 0/0/0/1", cmd_rdy, mv_vert_or_horiz, mv_indx, usurp); end
        pulse_send();
        vecs++; if (mv_vert_or_horiz !== 1'b1) begin errs++; $display("FAIL handoff_vh got %h want 1", mv_vert_or_horiz); end
        vecs++; if (cmd !== 16'h3BF1 || cmd_rdy !== 1'b1) begin errs++; $display("FAIL handoff_cmd got %h/%h want 3bf1/1", cmd, cmd_rdy); end
        // send_resp before acceptance is ignored
        pulse_send();
        vecs++; if (cmd_rdy !== 1'b1 || mv_vert_or_horiz !== 1'b1) begin errs++; $display("FAIL horz_early_send got rdy %h vh %h want 1/1", cmd_rdy, mv_vert_or_horiz); end
        pulse_clr();
        vecs++; if (resp !== 8'h5A || cmd_rdy !== 1'b0) begin errs++; $display("FAIL waith_resp got %h/%h want 5a/0", resp, cmd_rdy); end
        pulse_send();
        vecs++; if (mv_indx !== 5'd1) begin errs++; $display("FAIL handoff_idx got %0d want 1", mv_indx); end
        vecs++; if (cmd !== 16'h2002 || mv_vert_or_horiz !== 1'b0) begin errs++; $display("FAIL handoff_next got %h/%h want 2002/0", cmd, mv_vert_or_horiz); end
    endtask

    // Each entry: move, expected vertical and horizontal commands.
    task automatic test_headings();
        logic [7:0]  mv_t [5];
        logic [15:0] vc_t [5];
        logic [15:0] hc_t [5];
        mv_t = '{8'h08, 8'h40, 8'h00, 8'h0C, 8'h80};
        vc_t = '{16'h27F1, 16'h27F1, 16'h27F0, 16'h2001, 16'h2001};
        hc_t = '{16'h33F2, 16'h3BF2, 16'h33F0, 16'h33F2, 16'h3BF2};
        for (int i = 0; i < 5; i++) begin
            move = mv_t[i]; #1;
            vecs++; if (cmd !== vc_t[i]) begin errs++; $display("FAIL heading_vert[%0d] got %h want %h", i, cmd, vc_t[i]); end
            pulse_clr();
            pulse_send();
            vecs++; if (cmd !== hc_t[i]) begin errs++; $display("FAIL heading_horz[%0d] got %h want %h", i, cmd, hc_t[i]); end
            pulse_clr();
            pulse_send();
            vecs++; if (mv_indx !== 5'(i + 2)) begin errs++; $display("FAIL heading_idx[%0d] got %0d want %0d", i, mv_indx, i + 2); end
        end
    endtask

    // clr_cmd_rdy and send_resp together: only the current state's event counts.
    task automatic test_back_to_back();
        clr_cmd_rdy = 1'b1; send_resp = 1'b1;
        next_cycle();
        vecs++; if (cmd_rdy !== 1'b0 || mv_vert_or_horiz !== 1'b0) begin errs++; $display("FAIL both_in_vert got rdy %h vh %h want 0/0", cmd_rdy, mv_vert_or_horiz); end
        next_cycle();
        vecs++; if (cmd_rdy !== 1'b1 || mv_vert_or_horiz !== 1'b1) begin errs++; $display("FAIL both_in_waitv got rdy %h vh %h want 1/1", cmd_rdy, mv_vert_or_horiz); end
        next_cycle();
        vecs++; if (cmd_rdy !== 1'b0 || mv_vert_or_horiz !== 1'b1) begin errs++; $display("FAIL both_in_horz got rdy %h vh %h want 0/1", cmd_rdy, mv_vert_or_horiz); end
        clr_cmd_rdy = 1'b0; send_resp = 1'b0; #1;
    endtask

    task automatic test_full_tour();
        move = 8'h01;
        rst_n = 1'b0; #1;
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 24; i++) begin
            vecs++; if (mv_indx !== 5'(i) || cmd !== 16'h2002 || cmd_rdy !== 1'b1)
                begin errs++; $display("FAIL tour_vert[%0d] got idx %0d cmd %h rdy %h want %0d/2002/1", i, mv_indx, cmd, cmd_rdy, i); end
            pulse_clr();
            pulse_send();
            vecs++; if (cmd !== 16'h3BF1 || cmd_rdy !== 1'b1) begin errs++; $display("FAIL tour_horz[%0d] got %h/%h want 3bf1/1", i, cmd, cmd_rdy); end
            pulse_clr();
            send_resp = 1'b1; #1;
            vecs++; if (resp !== ((i == 23) ? 8'hA5 : 8'h5A)) begin errs++; $display("FAIL tour_resp[%0d] got %h want %h", i, resp, (i == 23) ? 8'hA5 : 8'h5A); end
            @(negedge clk);
            send_resp = 1'b0; #1;
        end
        vecs++; if (usurp !== 1'b0 || mv_vert_or_horiz !== 1'b0) begin errs++; $display("FAIL tour_done got us %h vh %h want 0/0", usurp, mv_vert_or_horiz); end
        cmd_UART = 16'h5555; cmd_rdy_UART = 1'b1; #1;
        vecs++; if (cmd !== 16'h5555 || cmd_rdy !== 1'b1 || resp !== 8'hA5) begin errs++; $display("FAIL tour_done_mux got %h/%h/%h want 5555/1/a5", cmd, cmd_rdy, resp); end
        cmd_rdy_UART = 1'b0;
        pulse_start();
        vecs++; if (usurp !== 1'b1 || mv_indx !== 5'd0 || cmd !== 16'h2002) begin errs++; $display("FAIL tour_restart got us %h idx %0d cmd %h want 1/0/2002", usurp, mv_indx, cmd); end
    endtask

    // From VERT@0: advance to WAIT_H@1, then drop reset between edges.
    task automatic test_async_reset();
        pulse_clr(); pulse_send(); pulse_clr(); pulse_send();
        pulse_clr(); pulse_send(); pulse_clr();
        vecs++; if (mv_indx !== 5'd1 || mv_vert_or_horiz !== 1'b1 || usurp !== 1'b1) begin errs++; $display("FAIL pre_reset got idx %0d vh %h us %h want 1/1/1", mv_indx, mv_vert_or_horiz, usurp); end
        #2;
        rst_n = 1'b0; #1;
        vecs++; if (usurp !== 1'b0 || mv_indx !== 5'd0 || mv_vert_or_horiz !== 1'b0) begin errs++; $display("FAIL async_reset got us %h idx %0d vh %h want 0/0/0", usurp, mv_indx, mv_vert_or_horiz); end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        vecs++; if (usurp !== 1'b0) begin errs++; $display("FAIL post_reset_idle got %h want 0", usurp); end
    endtask

    initial begin
        rst_n = 1'b0; start_tour = 1'b0; move = 8'h00;
        cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
        clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        #2;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1; #1;
        test_idle_passthrough();
        test_start();
        test_handoff();
        test_headings();
        test_back_to_back();
        test_full_tour();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/tour_move_sequencer.md
Name: tour_move_sequencer

Overview:
- Sits between the tour-solving logic and the command processor inside the knight top level.
- After a tour is solved (start_tour pulse), it reads the solved one-hot moves by index and converts each knight move into two motion commands: a vertical move, then a horizontal move with fanfare.
- While it sequences it takes control of the command path (usurp) away from the UART command path, and it generates the response codes.

Parameters:
- NUM_MOVES, 24, number of moves in a full tour; the last index is NUM_MOVES-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_tour  in  1  one-cycle pulse from the tour logic: solution ready
- move  in  8  one-hot move at index mv_indx, from the tour logic
- mv_indx  out  5  index of the move requested from the tour logic
- cmd_UART  in  16  command from the UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  acknowledge to the UART wrapper
- cmd  out  16  muxed command to the command processor
- cmd_rdy  out  1  muxed command valid
- clr_cmd_rdy  in  1  command processor has accepted the command
- send_resp  in  1  command processor has completed the command
- resp  out  8  response byte to the UART wrapper
- usurp  out  1  sequencer owns the command path
- mv_vert_or_horiz  out  1  0 = vertical leg, 1 = horizontal leg

Behaviour:

Command format:
- cmd[15:12] is the opcode: 4'h2 = move, 4'h3 = move with fanfare.
- cmd[11:4] is the heading: 8'h00 north, 8'h7F south, 8'h3F west, 8'hBF east.
- cmd[3:0] is the number of squares.

Move decode (bit: dx,dy):
- b0 +1,+2; b1 -1,+2; b2 -2,+1; b3 -2,-1; b4 -1,-2; b5 +1,-2; b6 +2,-1; b7 +2,+1.
- Vertical command: opcode 2, heading north if dy>0 else south, squares = |dy|.
- Horizontal command: opcode 3, heading east if dx>0 else west, squares = |dx|.
- If move is not one-hot, the lowest set bit wins.
- move==0 produces 0-square commands; the sequence still advances.

State machine (IDLE, VERT, WAIT_V, HORZ, WAIT_H):
- IDLE: start_tour -> VERT and mv_indx<=0.
- VERT: cmd_rdy=1; clr_cmd_rdy -> WAIT_V.
- WAIT_V: send_resp -> HORZ.
- HORZ: cmd_rdy=1; clr_cmd_rdy -> WAIT_H.
- WAIT_H on send_resp:
  - if mv_indx==NUM_MOVES-1 -> IDLE;
  - otherwise mv_indx<=mv_indx+1 -> VERT.

Derived outputs:
- usurp = (state != IDLE), registered via the state register.
- mv_vert_or_horiz = 1 in HORZ and WAIT_H.
- cmd is built combinationally from the current move and state. It is valid in the cycle after the state transition: one clk after send_resp ends the vertical leg, cmd already holds the horizontal command.

Muxing:
- usurp=1: cmd/cmd_rdy come from the sequencer; clr_cmd_rdy_UART=0; cmd_rdy_UART is ignored (not queued).
- usurp=0: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.

Response:
- resp = 8'hA5 when usurp=0, or when state==WAIT_H and mv_indx==NUM_MOVES-1 (final move).
- Otherwise resp = 8'h5A.

Reset:
- state=IDLE, mv_indx=0, usurp=0, mv_vert_or_horiz=0.
- cmd/cmd_rdy follow the UART inputs.
- Reset asserted mid-tour aborts immediately to IDLE.

Boundary conditions:
- start_tour outside IDLE is ignored.
- send_resp in VERT/HORZ (before acceptance) is ignored.
- clr_cmd_rdy in WAIT_V/WAIT_H is ignored.
- clr_cmd_rdy and send_resp in the same cycle: only the transition defined for the current state is taken.
- mv_indx never wraps; it saturates at NUM_MOVES-1 until IDLE.

Decomposition:
- Package tour_pkg holds:
  - state enum;
  - opcode constants (MOVE, MOVE_FANFARE);
  - heading constants (NORTH, SOUTH, WEST, EAST);
  - response constants (RESP_ACK=8'hA5, RESP_POS=8'h5A).
- Sub-module knight_move_decode: combinational, one-hot move -> {vert_heading, vert_sq, horz_heading, horz_sq}.
- The FSM, index counter and muxes stay in the parent.

Test Plan:
- Idle passthrough: cmd_UART=16'h0000 with cmd_rdy_UART=1 -> cmd=16'h0000, usurp=0; clr_cmd_rdy pulse -> clr_cmd_rdy_UART pulse; resp=8'hA5.
- Start with move=8'h01: start_tour pulse -> next cycle usurp=1, resp=8'h5A, cmd=16'h2002, cmd_rdy=1.
- Vertical->horizontal handoff, move=8'h01:
  - clr_cmd_rdy, then send_resp;
  - one clk later mv_vert_or_horiz=1 and cmd=16'h3BF1;
  - send_resp -> mv_indx=1.
- Heading coverage: move=8'h08 -> vertical 16'h27F1, horizontal 16'h33F2; move=8'h40 -> vertical 16'h27F1, horizontal 16'h3BF2.
- Full tour: 24 move pairs acknowledged -> resp=8'hA5 coincident with the final send_resp; next cycle usurp=0, state IDLE; a further start_tour restarts at mv_indx=0.
- Robustness:
  - start_tour and cmd_rdy_UART asserted in WAIT_V -> no effect;
  - rst_n low in WAIT_H -> usurp=0, mv_indx=0 asynchronously.
